uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Oversampling UART receiver with an integrated baud-tick generator. It converts the asynchronous serial line into parallel bytes plus a one-cycle valid pulse, which the debug unit uses to load instructions and commands. Each byte is sampled at mid-bit. The block rejects start-bit glitches and flags framing errors so that a corrupted byte never reaches the debug unit as valid data.

## Interface
- NB_DATA, 8, data bits per frame (LSB first, no parity, one stop bit)
- CLK_FREQ, 100_000_000, clk frequency in Hz
- BAUD_RATE, 19200, line rate in baud
- OVERSAMPLING, 16, ticks per bit; even, ≥4
- Derived DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLING), integer-truncated (325 at defaults); DIV ≥ 2 required

Ports:
- clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx  in  1  asynchronous serial line, idle high
- o_data  out  NB_DATA  last correctly framed byte; held until the next good frame
- o_rx_done  out  1  one-clk pulse when o_data updates
- o_frame_err  out  1  one-clk pulse when the stop bit is sampled low
- o_tick  out  1  one-clk oversampling tick (debug/observability)

## Operation
- **Synchronizer:** i_rx passes through 2 flops to produce rx_s. The flops reset to 1. All decisions use rx_s only.
- **Tick generator:** counter runs 0..DIV-1 and wraps. o_tick = 1 for exactly the clk in which counter == DIV-1. The counter free-runs and is never re-phased by the line.
- **Counters:**
  - s: 0..OVERSAMPLING-1, tick count within a bit.
  - n: 0..NB_DATA-1, bit index.
  - sh: NB_DATA shift register; on each data sample, rx_s enters the MSB and sh shifts right.
- **FSM** (advances only on clks with o_tick = 1, except where noted):
  - IDLE: rx_s == 0 → START, s = 0.
  - START: s increments. At s == OVERSAMPLING/2-1 (mid start bit):
    - rx_s == 0 → DATA, s = 0, n = 0.
    - rx_s == 1 → IDLE (glitch reject, no output).
  - DATA: s increments. At s == OVERSAMPLING-1: sample into sh, s = 0. If n == NB_DATA-1 → STOP, else n++.
  - STOP: s increments. At s == OVERSAMPLING-1:
    - rx_s == 1 → o_data = sh, pulse o_rx_done, → IDLE.
    - rx_s == 0 → pulse o_frame_err, o_data unchanged, → BRK.
  - BRK: wait for rx_s == 1 on a tick → IDLE. A line held low (break) never generates further frames or pulses.
- o_rx_done and o_frame_err are mutually exclusive and never asserted in consecutive clks.
- **Reset mid-frame:** the frame is abandoned with no pulse. State returns to IDLE, all counters and sh go to 0, and o_data goes to 0.

## Timing
- **Reset values:**
  - o_data = 0, o_rx_done = 0, o_frame_err = 0, o_tick = 0.
  - Tick counter = 0, state IDLE, sync flops = 1.
- First o_tick occurs DIV clks after reset deassertion.
- Synchronizer latency is 2 clks from an i_rx edge to rx_s.
- **Start detection:** the start edge is recognised on the first tick after rx_s falls, with up to 1 tick of jitter. Data bit k is sampled 8+16(k+1) ticks after start detection (OVERSAMPLING = 16), i.e. at mid-bit.
- **Result pulses:**
  - o_rx_done / o_frame_err assert in the clk after the stop-sample tick edge, for 1 clk. o_data is valid in that same clk.
  - Start-detect to pulse is 8+16·NB_DATA+16 ticks (152 at defaults).
- **Back-to-back frames:** IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is captured. There is no inter-frame gap requirement.
- Tolerance is about ±3% total baud mismatch at OVERSAMPLING = 16.

## Test plan
Bench parameters: CLK_FREQ = 3_200_000, BAUD_RATE = 20_000, OVERSAMPLING = 16, so DIV = 10 and one bit = 160 clks.

1. **Reset:** hold i_reset 5 clks with i_rx = 1 → all outputs 0; o_tick pulses every 10 clks starting 10 clks after release; no done or err pulses.
2. **Single byte:** send 0x55 → exactly one o_rx_done pulse, o_data = 0x55, o_frame_err never asserted.
3. **Back-to-back:** send 0xA3 then 0x0F with no idle gap → two o_rx_done pulses about 1600 clks apart, o_data = 0xA3 then 0x0F.
4. **Glitch:** drive i_rx low for 40 clks, then high → no pulse, FSM back in IDLE; a subsequent 0x3C is received correctly.
5. **Framing error and break:** send 0xFF with the stop bit low, then hold i_rx low for 2000 clks → one o_frame_err pulse, o_data keeps 0x3C, no further pulses while low; after release, 0x81 is received.
6. **Reset mid-frame:** assert i_reset during bit 4 of 0xC6 → no pulse, o_data = 0; the next frame 0x7E yields o_data = 0x7E.

Source files
------------

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Oversampling UART receiver with built-in baud-tick generator,
//               start-glitch rejection and framing-error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int NB_DATA      = 8,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int OVERSAMPLING = 16
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_tick
);

    localparam int c_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_S_W   = $clog2(OVERSAMPLING);
    localparam int c_N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_S_W-1:0]   c_S_HALF   = c_S_W'(OVERSAMPLING / 2 - 1);
    localparam logic [c_S_W-1:0]   c_S_LAST   = c_S_W'(OVERSAMPLING - 1);
    localparam logic [c_N_W-1:0]   c_N_LAST   = c_N_W'(NB_DATA - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BRK   = 3'd4;

    logic [1:0]         r_sync_q,  w_sync_d;
    logic [c_DIV_W-1:0] r_div_q,   w_div_d;
    logic [2:0]         r_state_q, w_state_d;
    logic [c_S_W-1:0]   r_s_q,     w_s_d;
    logic [c_N_W-1:0]   r_n_q,     w_n_d;
    logic [NB_DATA-1:0] r_sh_q,    w_sh_d;
    logic [NB_DATA-1:0] r_data_q,  w_data_d;
    logic               r_done_q,  w_done_d;
    logic               r_err_q,   w_err_d;
    logic               w_rx_s;
    logic               w_tick;

    assign w_rx_s   = r_sync_q[1];
    assign w_sync_d = {r_sync_q[0], i_rx};
    assign w_tick   = (r_div_q == c_DIV_LAST);
    assign w_div_d  = w_tick ? '0 : r_div_q + c_DIV_W'(1);

    always_comb begin
        w_state_d = r_state_q;
        w_s_d     = r_s_q;
        w_n_d     = r_n_q;
        w_sh_d    = r_sh_q;
        w_data_d  = r_data_q;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        if (w_tick) begin
            case (r_state_q)
                c_ST_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_d = c_ST_START;
                        w_s_d     = '0;
                    end
                end
                c_ST_START: begin
                    // Start bit must still be low at its midpoint, else it was a glitch
                    if (r_s_q == c_S_HALF) begin
                        if (!w_rx_s) begin
                            w_state_d = c_ST_DATA;
                            w_s_d     = '0;
                            w_n_d     = '0;
                        end else begin
                            w_state_d = c_ST_IDLE;
                        end
                    end else begin
                        w_s_d = r_s_q + c_S_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (r_s_q == c_S_LAST) begin
                        w_sh_d = {w_rx_s, r_sh_q[NB_DATA-1:1]};
                        w_s_d  = '0;
                        if (r_n_q == c_N_LAST) begin
                            w_state_d = c_ST_STOP;
                        end else begin
                            w_n_d = r_n_q + c_N_W'(1);
                        end
                    end else begin
                        w_s_d = r_s_q + c_S_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (r_s_q == c_S_LAST) begin
                        if (w_rx_s) begin
                            w_data_d  = r_sh_q;
                            w_done_d  = 1'b1;
                            w_state_d = c_ST_IDLE;
                        end else begin
                            w_err_d   = 1'b1;
                            w_state_d = c_ST_BRK;
                        end
                    end else begin
                        w_s_d = r_s_q + c_S_W'(1);
                    end
                end
                c_ST_BRK: begin
                    if (w_rx_s) begin
                        w_state_d = c_ST_IDLE;
                    end
                end
                default: w_state_d = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_sync_q  <= 2'b11;
            r_div_q   <= '0;
            r_state_q <= c_ST_IDLE;
            r_s_q     <= '0;
            r_n_q     <= '0;
            r_sh_q    <= '0;
            r_data_q  <= '0;
            r_done_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_div_q   <= w_div_d;
            r_state_q <= w_state_d;
            r_s_q     <= w_s_d;
            r_n_q     <= w_n_d;
            r_sh_q    <= w_sh_d;
            r_data_q  <= w_data_d;
            r_done_q  <= w_done_d;
            r_err_q   <= w_err_d;
        end
    end

    assign o_data      = r_data_q;
    assign o_rx_done   = r_done_q;
    assign o_frame_err = r_err_q;
    assign o_tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sampler
// Description : Randomised frame-level bench for uart_rx_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int NB       = 8;
    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 20_000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
    // Stop-bit midpoint is 9.5 bits after the start edge, plus sync/tick jitter
    localparam int LAT_MIN  = 19 * BIT / 2;
    localparam int LAT_MAX  = 19 * BIT / 2 + 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_rx = 1'b1;
    logic [NB-1:0] o_data;
    logic          o_rx_done;
    logic          o_frame_err;
    logic          o_tick;

    uart_rx_sampler #(
        .NB_DATA      (NB),
        .CLK_FREQ     (CLK_FREQ),
        .BAUD_RATE    (BAUD),
        .OVERSAMPLING (OS)
    ) u_dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_tick      (o_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            err;
        logic [NB-1:0] data;
        int            t0;
    } exp_t;

    exp_t          q[$];
    logic [NB-1:0] exp_data = '0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_pulse = -100;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every result pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!i_reset && (o_rx_done || o_frame_err)) begin
            check_eq("exclusive", 32'(o_rx_done & o_frame_err), 0);
            check_eq("pulse_gap", 32'(cyc - last_pulse > 1), 1);
            last_pulse = cyc;
            if (q.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, o_rx_done, o_frame_err}, 0);
            end else begin
                e   = q.pop_front();
                lat = cyc - e.t0;
                check_eq("kind_err", 32'(o_frame_err), 32'(e.err));
                if (!e.err) exp_data = e.data;
                check_eq("data", 32'(o_data), 32'(exp_data));
                check_eq("latency", (lat >= LAT_MIN && lat <= LAT_MAX) ? 32'(LAT_MIN) : 32'(lat), LAT_MIN);
            end
        end
    end

    task automatic drive_bits(input logic [NB-1:0] b, input logic stop, input int nbits);
        logic [NB+1:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            i_rx = f[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] b, input logic stop);
        exp_t e;
        e.err  = !stop;
        e.data = b;
        e.t0   = cyc;
        q.push_back(e);
        drive_bits(b, stop, NB + 2);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        check_eq("drain", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NB-1:0] b;
        logic          stop;
        logic [NB-1:0] v;

        // Reset and tick cadence
        @(negedge clk);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_data", 32'(o_data), 0);
        check_eq("rst_done", 32'(o_rx_done), 0);
        check_eq("rst_err", 32'(o_frame_err), 0);
        check_eq("rst_tick", 32'(o_tick), 0);
        i_reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            check_eq("tick", 32'(o_tick), 32'((i % DIV) == DIV - 1));
        end
        @(negedge clk);

        // Single byte
        send_frame(8'h55, 1'b1);
        idle(BIT);
        wait_drain();
        check_eq("hold_55", 32'(o_data), 32'h55);

        // Back-to-back
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(BIT);
        wait_drain();
        check_eq("hold_0f", 32'(o_data), 32'h0F);

        // Start-bit glitches, fixed then random widths
        i_rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(200);
        repeat (4) begin
            i_rx = 1'b0;
            repeat ($urandom_range(1, 60)) @(negedge clk);
            idle(200);
        end
        check_eq("glitch_hold", 32'(o_data), 32'h0F);
        send_frame(8'h3C, 1'b1);
        idle(BIT);
        wait_drain();
        check_eq("hold_3c", 32'(o_data), 32'h3C);

        // Framing error followed by a long break
        send_frame(8'hFF, 1'b0);
        repeat (2000) @(negedge clk);
        wait_drain();
        check_eq("break_hold", 32'(o_data), 32'h3C);
        idle(200);
        send_frame(8'h81, 1'b1);
        idle(BIT);
        wait_drain();
        check_eq("hold_81", 32'(o_data), 32'h81);

        // Reset in the middle of bit 4
        v = 8'hC6;
        drive_bits(v, 1'b1, 5);
        i_rx = v[4];
        repeat (BIT / 2) @(negedge clk);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(negedge clk);
        i_reset  = 1'b0;
        exp_data = '0;
        idle(400);
        check_eq("midreset_data", 32'(o_data), 0);
        send_frame(8'h7E, 1'b1);
        idle(BIT);
        wait_drain();
        check_eq("hold_7e", 32'(o_data), 32'h7E);

        // Random frames, some with bad stop bits, random gaps incl. none
        repeat (8) begin
            b    = NB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            if (!stop) begin
                repeat ($urandom_range(0, 400)) @(negedge clk);
                idle(30 + $urandom_range(0, 100));
            end else if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 400));
            end
        end
        idle(BIT);
        wait_drain();
        check_eq("final_data", 32'(o_data), 32'(exp_data));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
